// File: rtl/ysyx_24110006_idu.sv
// RV32I decode stage with a one-entry output register and valid/ready handshakes.
// Define YSYX_24110006_ILLEGAL_INSN_EN to flag undecodable encodings on out_illegal.
module ysyx_24110006_idu #(
    parameter int unsigned      XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = 32'h8000_0000
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [3:0]      out_alu_t,
    output logic            out_sub,
    output logic            out_sign,
    output logic            out_alu_sra,
    output logic            out_a_pc,
    output logic            out_b_imm,
    output logic            out_reg_wen,
    output logic [5:0]      out_ctl,
    output logic [2:0]      out_funct3,
    output logic            out_illegal
);

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpFence  = 7'b0001111;
    localparam logic [6:0] OpSystem = 7'b1110011;

    localparam logic [5:0] CtlJal    = 6'b100000;
    localparam logic [5:0] CtlJalr   = 6'b010000;
    localparam logic [5:0] CtlBranch = 6'b001000;
    localparam logic [5:0] CtlLoad   = 6'b000100;
    localparam logic [5:0] CtlStore  = 6'b000010;
    localparam logic [5:0] CtlEbreak = 6'b000001;

    typedef struct packed {
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [3:0]  alu_t;
        logic        sub;
        logic        sign;
        logic        sra;
        logic        a_pc;
        logic        b_imm;
        logic        reg_wen;
        logic [5:0]  ctl;
        logic [2:0]  funct3;
        logic        illegal;
    } dec_t;

    typedef enum logic {StEmpty, StFull} state_e;

    state_e      r_state;
    state_e      w_state_nxt;
    dec_t        r_dec;
    dec_t        w_dec;
    logic [31:0] r_pc;
    logic        w_accept;
    logic        w_bad;

    logic [6:0]  w_opcode;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [4:0]  w_rd;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;

    assign w_opcode = in_inst[6:0];
    assign w_f3     = in_inst[14:12];
    assign w_f7     = in_inst[31:25];
    assign w_rs1    = in_inst[19:15];
    assign w_rs2    = in_inst[24:20];
    assign w_rd     = in_inst[11:7];

    assign w_imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
    assign w_imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    assign w_imm_b = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                      in_inst[11:8], 1'b0};
    assign w_imm_u = {in_inst[31:12], 12'b0};
    assign w_imm_j = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                      in_inst[30:21], 1'b0};

    // Default packet is ADDI x0,x0,0; fence/ecall and (without the macro) bad encodings keep it.
    always_comb begin
        w_dec       = '0;
        w_dec.b_imm = 1'b1;
        w_bad       = 1'b0;
        case (w_opcode)
            OpLui: begin
                w_dec.rd      = w_rd;
                w_dec.imm     = w_imm_u;
                w_dec.reg_wen = 1'b1;
            end
            OpAuipc: begin
                w_dec.rd      = w_rd;
                w_dec.imm     = w_imm_u;
                w_dec.a_pc    = 1'b1;
                w_dec.reg_wen = 1'b1;
            end
            OpJal: begin
                w_dec.rd      = w_rd;
                w_dec.imm     = w_imm_j;
                w_dec.a_pc    = 1'b1;
                w_dec.b_imm   = 1'b0;
                w_dec.reg_wen = 1'b1;
                w_dec.ctl     = CtlJal;
            end
            OpJalr: begin
                w_dec.rd      = w_rd;
                w_dec.rs1     = w_rs1;
                w_dec.imm     = w_imm_i;
                w_dec.a_pc    = 1'b1;
                w_dec.b_imm   = 1'b0;
                w_dec.reg_wen = 1'b1;
                w_dec.ctl     = CtlJalr;
                w_bad         = (w_f3 != 3'b000);
            end
            OpBranch: begin
                w_dec.rs1   = w_rs1;
                w_dec.rs2   = w_rs2;
                w_dec.imm   = w_imm_b;
                w_dec.b_imm = 1'b0;
                w_dec.alu_t = {1'b1, w_f3};
                w_dec.sub   = 1'b1;
                w_dec.sign  = (w_f3 == 3'b100) || (w_f3 == 3'b101);
                w_dec.ctl   = CtlBranch;
                w_bad       = (w_f3 == 3'b010) || (w_f3 == 3'b011);
            end
            OpLoad: begin
                w_dec.rd      = w_rd;
                w_dec.rs1     = w_rs1;
                w_dec.imm     = w_imm_i;
                w_dec.reg_wen = 1'b1;
                w_dec.ctl     = CtlLoad;
                w_dec.funct3  = w_f3;
                w_bad         = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
            end
            OpStore: begin
                w_dec.rs1    = w_rs1;
                w_dec.rs2    = w_rs2;
                w_dec.imm    = w_imm_s;
                w_dec.ctl    = CtlStore;
                w_dec.funct3 = w_f3;
                w_bad        = (w_f3 > 3'b010);
            end
            OpImm: begin
                w_dec.rd      = w_rd;
                w_dec.rs1     = w_rs1;
                w_dec.imm     = w_imm_i;
                w_dec.reg_wen = 1'b1;
                w_dec.alu_t   = {1'b0, w_f3};
                w_dec.sub     = (w_f3 == 3'b010) || (w_f3 == 3'b011);
                w_dec.sign    = (w_f3 == 3'b010);
                if (w_f3 == 3'b001) begin
                    w_dec.imm = {27'b0, in_inst[24:20]};
                    w_bad     = (w_f7 != 7'b0000000);
                end else if (w_f3 == 3'b101) begin
                    w_dec.imm = {27'b0, in_inst[24:20]};
                    w_dec.sra = in_inst[30];
                    w_bad     = (w_f7 != 7'b0000000) && (w_f7 != 7'b0100000);
                end
            end
            OpReg: begin
                w_dec.rd      = w_rd;
                w_dec.rs1     = w_rs1;
                w_dec.rs2     = w_rs2;
                w_dec.b_imm   = 1'b0;
                w_dec.reg_wen = 1'b1;
                w_dec.alu_t   = {1'b0, w_f3};
                if (w_f7 == 7'b0000000) begin
                    w_dec.sub  = (w_f3 == 3'b010) || (w_f3 == 3'b011);
                    w_dec.sign = (w_f3 == 3'b010);
                end else if (w_f7 == 7'b0100000 && w_f3 == 3'b000) begin
                    w_dec.sub = 1'b1;
                end else if (w_f7 == 7'b0100000 && w_f3 == 3'b101) begin
                    w_dec.sra = 1'b1;
                end else begin
                    w_bad = 1'b1;
                end
            end
            OpFence: ;
            OpSystem: begin
                if (in_inst == 32'h0010_0073) begin
                    w_dec.ctl = CtlEbreak;
                end else if (in_inst != 32'h0000_0073) begin
                    w_bad = 1'b1;
                end
            end
            default: w_bad = 1'b1;
        endcase

        if (w_dec.rd == 5'd0) begin
            w_dec.reg_wen = 1'b0;
        end

        if (w_bad) begin
            w_dec       = '0;
            w_dec.b_imm = 1'b1;
`ifdef YSYX_24110006_ILLEGAL_INSN_EN
            w_dec.illegal = 1'b1;
`endif
        end
    end

    assign out_valid = (r_state == StFull);
    assign in_ready  = !out_valid || out_ready;
    assign w_accept  = in_valid && in_ready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StEmpty: if (w_accept) w_state_nxt = StFull;
            StFull: begin
                if (w_accept) begin
                    w_state_nxt = StFull;
                end else if (out_ready) begin
                    w_state_nxt = StEmpty;
                end
            end
            default: w_state_nxt = StEmpty;
        endcase
        if (flush) begin
            w_state_nxt = StEmpty;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= StEmpty;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A flushed same-cycle accept must not disturb the held packet contents.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc  <= RESET_PC;
            r_dec <= '0;
        end else if (w_accept && !flush) begin
            r_pc  <= in_pc;
            r_dec <= w_dec;
        end
    end

    assign out_pc      = r_pc;
    assign out_imm     = r_dec.imm;
    assign out_rs1     = r_dec.rs1;
    assign out_rs2     = r_dec.rs2;
    assign out_rd      = r_dec.rd;
    assign out_alu_t   = r_dec.alu_t;
    assign out_sub     = r_dec.sub;
    assign out_sign    = r_dec.sign;
    assign out_alu_sra = r_dec.sra;
    assign out_a_pc    = r_dec.a_pc;
    assign out_b_imm   = r_dec.b_imm;
    assign out_reg_wen = r_dec.reg_wen;
    assign out_ctl     = r_dec.ctl;
    assign out_funct3  = r_dec.funct3;
    assign out_illegal = r_dec.illegal;

endmodule
